sr_capture_ctrl: RTL

Sequencer for an 8-bit serial-in shift-register chain: times each shift with a programmable bit-period divider and counts a programmable number of bits per frame. It presents the captured word on a valid/ready output handshake. It sits between a serial source (sensor or link pin, already synchronised to clk) and a parallel consumer. Both the shift chain and the output holding register live inside the block.

---
 rtl/sr_capture_ctrl.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/sr_capture_ctrl.sv
// sr_capture_ctrl: sequencer for a DATA_W-bit serial-in shift chain.
// A frame starts on `start` in IDLE. ser_in is shifted in once every
// (cfg_div+1) clk cycles until cfg_len bits are collected. The word is then
// presented right-justified on a valid/ready output with a sticky overrun flag.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   start, abort           frame start (IDLE only), synchronous abort
//   ser_in                 serial data, already synchronised to clk
//   cfg_div, cfg_len       bit period minus 1 / bits per frame, latched at start
//   shift_en, busy, sr_q   shift strobe, frame in progress, live chain
//   data_out, data_valid,
//   data_ready             captured word handshake
//   overrun, clr_ovr       sticky overwrite flag and its clear
module sr_capture_ctrl #(
  parameter int DATA_W = 8,
  parameter int DIV_W  = 16,
  parameter int LEN_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              ser_in,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [LEN_W-1:0]  cfg_len,
  output logic              shift_en,
  output logic              busy,
  output logic [DATA_W-1:0] sr_q,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  input  logic              data_ready,
  output logic              overrun,
  input  logic              clr_ovr
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] sr_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              data_valid_q, data_valid_d;
  logic              overrun_q, overrun_d;

  logic [LEN_W-1:0]  len_sane;
  logic [DATA_W-1:0] sr_shift;
  logic [DATA_W-1:0] len_mask;
  logic              last_shift;
  logic              ovr_set;

  always_comb begin
    // 0 or anything wider than the chain means a full-width frame
    if (cfg_len == '0 || 32'(cfg_len) > DATA_W) begin
      len_sane = LEN_W'(DATA_W);
    end else begin
      len_sane = cfg_len;
    end

    sr_shift = {sr_q[DATA_W-2:0], ser_in};
    for (int unsigned i = 0; i < DATA_W; i++) begin
      len_mask[i] = (i < 32'(len_q));
    end

    // abort suppresses the strobe so no shift happens on the abort edge
    shift_en   = (state_q == ST_RUN) && (div_cnt_q == '0) && !abort;
    last_shift = shift_en && (bit_cnt_q == len_q - LEN_W'(1));
    ovr_set    = last_shift && data_valid_q && !data_ready;

    state_d      = state_q;
    div_d        = div_q;
    div_cnt_d    = div_cnt_q;
    len_d        = len_q;
    bit_cnt_d    = bit_cnt_q;
    sr_d         = sr_q;
    data_out_d   = data_out_q;
    data_valid_d = data_valid_q;

    if (data_valid_q && data_ready) begin
      data_valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          div_d     = cfg_div;
          len_d     = len_sane;
          sr_d      = '0;
          div_cnt_d = cfg_div;
          bit_cnt_d = '0;
          state_d   = ST_RUN;
        end
      end
      default: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (div_cnt_q != '0) begin
          div_cnt_d = div_cnt_q - DIV_W'(1);
        end else begin
          sr_d      = sr_shift;
          div_cnt_d = div_q;
          bit_cnt_d = bit_cnt_q + LEN_W'(1);
          if (last_shift) begin
            // completion overrides a same-edge consumption
            data_out_d   = sr_shift & len_mask;
            data_valid_d = 1'b1;
            state_d      = ST_IDLE;
          end
        end
      end
    endcase

    if (ovr_set) begin
      overrun_d = 1'b1;
    end else if (clr_ovr) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      div_q        <= '0;
      div_cnt_q    <= '0;
      len_q        <= '0;
      bit_cnt_q    <= '0;
      sr_q         <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      div_cnt_q    <= div_cnt_d;
      len_q        <= len_d;
      bit_cnt_q    <= bit_cnt_d;
      sr_q         <= sr_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      overrun_q    <= overrun_d;
    end
  end

  assign busy       = (state_q == ST_RUN);
  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign overrun    = overrun_q;

endmodule
